// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline boundary registers: per-boundary widths,
// decode->exm control field layout and the skid-stage occupancy states.
package pipe_pkg;

  localparam int DEC_EXM_CTRL_W = 23;
  localparam int DEC_EXM_DATA_W = 38;

  // decode->exm control layout, LSB first: alu_function, wb_selector, branch_selector, flags
  localparam int ALU_FN_LSB  = 0;
  localparam int ALU_FN_W    = 3;
  localparam int WB_SEL_LSB  = ALU_FN_LSB + ALU_FN_W;
  localparam int WB_SEL_W    = 2;
  localparam int BR_SEL_LSB  = WB_SEL_LSB + WB_SEL_W;
  localparam int BR_SEL_W    = 3;
  localparam int FLAGS_LSB   = BR_SEL_LSB + BR_SEL_W;
  localparam int FLAGS_N     = 15;
  localparam int DEC_EXM_CTRL_USED = FLAGS_LSB + FLAGS_N;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } slot_state_t;

  function automatic logic [DEC_EXM_CTRL_W-1:0] pack_dec_exm_ctrl(
    input logic [ALU_FN_W-1:0] alu_function,
    input logic [WB_SEL_W-1:0] wb_selector,
    input logic [BR_SEL_W-1:0] branch_selector,
    input logic [FLAGS_N-1:0]  flags
  );
    return {flags, branch_selector, wb_selector, alu_function};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: valid + control + data registers with load and clear.
// Priority is reset, then clear, then load; data survives clear unless clear_data is set.
module pipe_slot #(
  parameter int CTRL_W = 23,
  parameter int DATA_W = 38
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              clear_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // slot register update
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (clear_data) begin
        data <= '0;
      end else begin
        data <= data;
      end
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end else begin
      valid <= valid;
      ctrl  <= ctrl;
      data  <= data;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer and flush-to-bubble.
// Upstream ready comes straight from the skid valid register, so it never depends on i_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W          = DEC_EXM_CTRL_W,
  parameter int DATA_W          = DEC_EXM_DATA_W,
  parameter int FLUSH_ZERO_DATA = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);

  slot_state_t state;
  slot_state_t state_next;

  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_from_skid;
  logic              main_clear;
  logic              skid_load;
  logic              skid_clear;
  logic              clear_data;
  logic              main_valid;
  logic              skid_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] main_in_ctrl;
  logic [DATA_W-1:0] main_in_data;

  assign o_ready  = ~skid_valid & ~i_reset;
  assign o_valid  = main_valid;
  assign o_full   = skid_valid;
  assign o_ctrl   = main_ctrl;
  assign o_data   = main_data;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = main_valid & i_ready;

  assign main_in_ctrl = main_from_skid ? skid_ctrl : i_ctrl;
  assign main_in_data = main_from_skid ? skid_data : i_data;

  // occupancy state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // next-state and slot control; flush overrides every transfer
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    clear_data     = 1'b0;
    if (i_flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
      clear_data = (FLUSH_ZERO_DATA != 0);
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load  = 1'b1;
            state_next = ST_ONE;
          end else begin
            state_next = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load  = 1'b1;
            state_next = ST_ONE;
          end else if (in_fire) begin
            // stall arrived after ready was already granted: park the entry
            skid_load  = 1'b1;
            state_next = ST_TWO;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_next = ST_EMPTY;
          end else begin
            state_next = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_next     = ST_ONE;
          end else begin
            state_next = ST_TWO;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          clear_data = 1'b1;
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk        (i_clk),
    .reset      (i_reset),
    .load       (main_load),
    .clear      (main_clear),
    .clear_data (clear_data),
    .load_ctrl  (main_in_ctrl),
    .load_data  (main_in_data),
    .valid      (main_valid),
    .ctrl       (main_ctrl),
    .data       (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk        (i_clk),
    .reset      (i_reset),
    .load       (skid_load),
    .clear      (skid_clear),
    .clear_data (clear_data),
    .load_ctrl  (i_ctrl),
    .load_data  (i_data),
    .valid      (skid_valid),
    .ctrl       (skid_ctrl),
    .data       (skid_data)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a FIFO-of-at-most-two reference model
// checked against two instances (flush zeroes data / flush holds data).
module tb_pipe_skid_stage;

  localparam int CW = 23;
  localparam int DW = 38;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_valid = 1'b0;
  logic [CW-1:0] i_ctrl = '0;
  logic [DW-1:0] i_data = '0;
  logic          i_flush = 1'b0;
  logic          i_ready = 1'b0;

  logic          rdy0, val0, full0, rdy1, val1, full1;
  logic [CW-1:0] ctrl0, ctrl1;
  logic [DW-1:0] data0, data1;

  int n_chk  = 0;
  int n_fail = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .FLUSH_ZERO_DATA(1)) dut0 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(rdy0),
    .i_ctrl(i_ctrl), .i_data(i_data), .i_flush(i_flush), .o_valid(val0),
    .i_ready(i_ready), .o_ctrl(ctrl0), .o_data(data0), .o_full(full0)
  );

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .FLUSH_ZERO_DATA(0)) dut1 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(rdy1),
    .i_ctrl(i_ctrl), .i_data(i_data), .i_flush(i_flush), .o_valid(val1),
    .i_ready(i_ready), .o_ctrl(ctrl1), .o_data(data1), .o_full(full1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: at most two held entries, flush/reset empty it
  always @(posedge clk) begin
    bit in_f, out_f;
    if (i_reset || i_flush) begin
      q.delete();
    end else begin
      in_f  = i_valid && (q.size() < 2);
      out_f = (q.size() > 0) && i_ready;
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back('{c: i_ctrl, d: i_data});
    end
  end

  // monitor: compare both instances against the model's head entry
  always @(negedge clk) begin
    int   sz;
    ent_t h;
    sz = q.size();
    h  = (sz > 0) ? q[0] : '0;
    chk("valid0", 64'(val0), 64'(sz > 0));
    chk("ready0", 64'(rdy0), 64'(!i_reset && sz < 2));
    chk("full0",  64'(full0), 64'(sz == 2));
    chk("ctrl0",  64'(ctrl0), 64'(h.c));
    chk("valid1", 64'(val1), 64'(sz > 0));
    chk("ready1", 64'(rdy1), 64'(!i_reset && sz < 2));
    chk("full1",  64'(full1), 64'(sz == 2));
    chk("ctrl1",  64'(ctrl1), 64'(h.c));
    if (sz > 0) begin
      chk("data0", 64'(data0), 64'(h.d));
      chk("data1", 64'(data1), 64'(h.d));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic f);
    i_valid = v; i_ctrl = c; i_data = d; i_ready = r; i_flush = f;
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_data0", 64'(data0), 64'd0);
    chk("rst_data1", 64'(data1), 64'd0);
    i_reset = 1'b0;

    // streaming 1,2,3
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, CW'(k), DW'(k * 16), 1'b1, 1'b0);
      cyc();
      chk("stream_ctrl", 64'(ctrl0), 64'(k));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (2) cyc();

    // stall absorb and long stall
    drive(1'b1, CW'(12'h0A0), DW'(38'h1), 1'b0, 1'b0);
    cyc();
    drive(1'b1, CW'(12'h0B0), DW'(38'h2), 1'b0, 1'b0);
    cyc();
    chk("absorb_full", 64'(full0), 64'd1);
    chk("absorb_ctrl", 64'(ctrl0), 64'h0A0);
    drive(1'b1, CW'(12'h0C0), DW'(38'h3), 1'b0, 1'b0);
    repeat (10) cyc();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    chk("release_ctrl", 64'(ctrl0), 64'h0B0);
    chk("release_ready", 64'(rdy0), 64'd1);
    repeat (2) cyc();

    // flush in TWO with a same-cycle input
    drive(1'b1, CW'(12'h0C0), DW'(38'h1234), 1'b0, 1'b0);
    cyc();
    drive(1'b1, CW'(12'h0D0), DW'(38'h5678), 1'b0, 1'b0);
    cyc();
    drive(1'b1, CW'(12'h0EE), DW'(38'h9999), 1'b1, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_valid", 64'(val0), 64'd0);
    chk("flush_data0", 64'(data0), 64'd0);
    chk("flush_data1", 64'(data1), 64'h1234);
    chk("flush_full", 64'(full0), 64'd0);
    repeat (2) cyc();

    // randomized traffic with occasional flushes
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(3) != 0), CW'($urandom), DW'({$urandom, $urandom}),
            ($urandom_range(3) != 0), ($urandom_range(15) == 0));
      cyc();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) cyc();

    // reset while in TWO
    drive(1'b1, CW'(12'h111), DW'(38'h11), 1'b0, 1'b0);
    cyc();
    drive(1'b1, CW'(12'h222), DW'(38'h22), 1'b0, 1'b0);
    cyc();
    i_reset = 1'b1;
    #1;
    chk("rst_ready_low", 64'(rdy0), 64'd0);
    cyc();
    i_reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("rst2_valid", 64'(val0), 64'd0);
    chk("rst2_ctrl", 64'(ctrl0), 64'd0);
    chk("rst2_data0", 64'(data0), 64'd0);
    chk("rst2_data1", 64'(data1), 64'd0);
    chk("rst2_full", 64'(full0), 64'd0);
    chk("rst2_ready", 64'(rdy0), 64'd1);
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
